execute_divide: RTL

- Iterative radix-2 divider for the execute stage; covers DIV, IDIV and AAM.
- It is the inverse-operation companion to the execute-stage multiplier. It uses the same start and busy handshake style, so the execute control logic treats both units alike.
- It divides EDX:EAX, DX:AX or AX by src (8, 16 or 32 bit), or divides AL by an immediate for AAM.
- It returns quotient, remainder and a divide-error (#DE) flag.

---
 rtl/execute_divide.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/execute_divide.sv
// Execute-stage iterative radix-2 divider for DIV, IDIV and AAM.
// Produces a zero-extended quotient and remainder plus a #DE flag. The start
// and busy handshake matches the execute-stage multiplier.

`ifndef CMD_DIV
`define CMD_DIV  7'd20
`endif
`ifndef CMD_IDIV
`define CMD_IDIV 7'd21
`endif
`ifndef CMD_AAM
`define CMD_AAM  7'd22
`endif

module execute_divide (
    input  logic        clk,
    input  logic        rst,
    input  logic        exe_reset,
    input  logic [6:0]  exe_cmd,
    input  logic        exe_is_8bit,
    input  logic        exe_operand_16bit,
    input  logic        exe_operand_32bit,
    input  logic [31:0] eax,
    input  logic [31:0] edx,
    input  logic [31:0] src,
    output logic        div_busy,
    output logic [31:0] div_quotient,
    output logic [31:0] div_remainder,
    output logic        exe_div_exception
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        W_8,
        W_16,
        W_32
    } width_t;

    state_t      state_q, state_d;
    width_t      width_q, width_d;
    logic        signed_q, signed_d;
    logic [63:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] dvs_mag_q, dvs_mag_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] low_q, low_d;
    logic [31:0] quo_q, quo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        quo_neg_q, quo_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic [31:0] quotient_q, quotient_d;
    logic [31:0] remainder_q, remainder_d;
    logic        exc_q, exc_d;

    logic        start_req;
    logic        is_signed_cmd;
    logic        is_aam;
    width_t      width_in;
    logic [63:0] dvd_in;
    logic [31:0] dvs_in;

    logic [63:0] dvd_mask;
    logic [31:0] w_mask;
    logic [31:0] pos_max;
    logic        dvd_sign;
    logic        dvs_sign;
    logic [63:0] abs_dvd;
    logic [31:0] abs_dvs;
    logic [31:0] hi_half;
    logic [31:0] lo_aligned;
    logic [4:0]  cnt_init;

    logic [32:0] shifted;
    logic        trial_ok;
    logic [31:0] quo_signed;
    logic [31:0] rem_signed;
    logic        idiv_overflow;

    assign is_aam        = (exe_cmd == `CMD_AAM);
    assign is_signed_cmd = (exe_cmd == `CMD_IDIV);
    assign start_req     = (exe_cmd == `CMD_DIV) || is_signed_cmd || is_aam;

    // Decode operand width and gather dividend/divisor from the register inputs on a start request.
    always_comb begin
        width_in = W_32;
        dvd_in   = {edx, eax};
        dvs_in   = src;
        if (is_aam) begin
            width_in = W_8;
            dvd_in   = {56'd0, eax[7:0]};
            dvs_in   = {24'd0, src[7:0]};
        end else if (exe_is_8bit) begin
            width_in = W_8;
            dvd_in   = {48'd0, eax[15:0]};
            dvs_in   = {24'd0, src[7:0]};
        end else if (exe_operand_16bit) begin
            width_in = W_16;
            dvd_in   = {32'd0, edx[15:0], eax[15:0]};
            dvs_in   = {16'd0, src[15:0]};
        end else if (exe_operand_32bit) begin
            width_in = W_32;
        end
    end

    // Width-dependent masks, sign bits and the split of the dividend magnitude into halves.
    always_comb begin
        case (width_q)
            W_8: begin
                dvd_mask = 64'h0000_0000_0000_FFFF;
                w_mask   = 32'h0000_00FF;
                pos_max  = 32'h0000_007F;
                dvd_sign = dvd_q[15];
                dvs_sign = dvs_q[7];
                cnt_init = 5'd7;
            end
            W_16: begin
                dvd_mask = 64'h0000_0000_FFFF_FFFF;
                w_mask   = 32'h0000_FFFF;
                pos_max  = 32'h0000_7FFF;
                dvd_sign = dvd_q[31];
                dvs_sign = dvs_q[15];
                cnt_init = 5'd15;
            end
            default: begin
                dvd_mask = 64'hFFFF_FFFF_FFFF_FFFF;
                w_mask   = 32'hFFFF_FFFF;
                pos_max  = 32'h7FFF_FFFF;
                dvd_sign = dvd_q[63];
                dvs_sign = dvs_q[31];
                cnt_init = 5'd31;
            end
        endcase

        abs_dvd = (signed_q && dvd_sign) ? ((-dvd_q) & dvd_mask) : dvd_q;
        abs_dvs = (signed_q && dvs_sign) ? ((-dvs_q) & w_mask) : dvs_q;

        case (width_q)
            W_8: begin
                hi_half    = {24'd0, abs_dvd[15:8]};
                lo_aligned = {abs_dvd[7:0], 24'd0};
            end
            W_16: begin
                hi_half    = {16'd0, abs_dvd[31:16]};
                lo_aligned = {abs_dvd[15:0], 16'd0};
            end
            default: begin
                hi_half    = abs_dvd[63:32];
                lo_aligned = abs_dvd[31:0];
            end
        endcase
    end

    // One restoring-division step plus the sign fix-up and signed range check for the final result.
    always_comb begin
        shifted       = {rem_q, low_q[31]};
        trial_ok      = (shifted >= {1'b0, dvs_mag_q});
        quo_signed    = quo_neg_q ? ((-quo_q) & w_mask) : quo_q;
        rem_signed    = rem_neg_q ? ((-rem_q) & w_mask) : rem_q;
        idiv_overflow = signed_q && (quo_neg_q ? (quo_q > (pos_max + 32'd1))
                                               : (quo_q > pos_max));
    end

    // Next-state and datapath update for the divide sequencer; a pipeline flush overrides everything.
    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        signed_d    = signed_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        dvs_mag_d   = dvs_mag_q;
        rem_d       = rem_q;
        low_d       = low_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        quo_neg_d   = quo_neg_q;
        rem_neg_d   = rem_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        exc_d       = exc_q;

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    state_d  = S_PREP;
                    width_d  = width_in;
                    signed_d = is_signed_cmd;
                    dvd_d    = dvd_in;
                    dvs_d    = dvs_in;
                end
            end
            S_PREP: begin
                quo_neg_d = signed_q & (dvd_sign ^ dvs_sign);
                rem_neg_d = signed_q & dvd_sign;
                dvs_mag_d = abs_dvs;
                if ((dvs_q == 32'd0) || (hi_half >= abs_dvs)) begin
                    exc_d       = 1'b1;
                    quotient_d  = 32'd0;
                    remainder_d = 32'd0;
                    state_d     = S_DONE;
                end else begin
                    rem_d   = hi_half;
                    low_d   = lo_aligned;
                    quo_d   = 32'd0;
                    cnt_d   = cnt_init;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                rem_d = trial_ok ? (shifted[31:0] - dvs_mag_q) : shifted[31:0];
                quo_d = {quo_q[30:0], trial_ok};
                low_d = {low_q[30:0], 1'b0};
                if (cnt_q == 5'd0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_FIX: begin
                quotient_d  = quo_signed;
                remainder_d = rem_signed;
                exc_d       = idiv_overflow;
                state_d     = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (exe_reset) begin
            state_d = S_IDLE;
            exc_d   = 1'b0;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            width_q     <= W_8;
            signed_q    <= 1'b0;
            dvd_q       <= 64'd0;
            dvs_q       <= 32'd0;
            dvs_mag_q   <= 32'd0;
            rem_q       <= 32'd0;
            low_q       <= 32'd0;
            quo_q       <= 32'd0;
            cnt_q       <= 5'd0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
            exc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            signed_q    <= signed_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            dvs_mag_q   <= dvs_mag_d;
            rem_q       <= rem_d;
            low_q       <= low_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            quo_neg_q   <= quo_neg_d;
            rem_neg_q   <= rem_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            exc_q       <= exc_d;
        end
    end

    assign div_busy          = (state_q != S_DONE);
    assign div_quotient      = quotient_q;
    assign div_remainder     = remainder_q;
    assign exe_div_exception = exc_q;

endmodule
